// File: rtl/riscv_legacy_cpu_if.sv
// Observation bus of the single-cycle core: decode fields and datapath values for the
// instruction currently at pc.
interface riscv_legacy_cpu_if;
  logic        reg_we;
  logic        mem_we;
  logic [1:0]  imm_src;      // 0:I 1:S 2:B 3:J
  logic [2:0]  alu_ctrl;     // 0:ADD 1:SUB 2:AND 3:OR 5:SLT
  logic        alu_src;      // 0:rs2 1:immediate
  logic [1:0]  res_src;      // 0:ALU 1:memory 2:pc+4
  logic        pc_src;       // 0:pc+4 1:pc+imm
  logic [31:0] instr;
  logic [31:0] alu_out;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_wd_data;
  logic [31:0] pc;

  modport master (
    output reg_we, mem_we, imm_src, alu_ctrl, alu_src, res_src, pc_src,
    output instr, alu_out, mem_rd_data, mem_wd_data, pc
  );

  modport slave (
    input reg_we, mem_we, imm_src, alu_ctrl, alu_src, res_src, pc_src,
    input instr, alu_out, mem_rd_data, mem_wd_data, pc
  );
endinterface

// File: rtl/riscv_legacy_cpu.sv
// Single-cycle RV32I subset core (lw/sw/addi-class/R-type/beq/jal) with instruction ROM
// taken from IMEM_INIT and a word-addressed data RAM.
module riscv_legacy_cpu #(
  parameter int unsigned INSTR_WORDS = 64,
  parameter int unsigned DATA_WORDS  = 64,
  parameter logic [31:0] IMEM_INIT [INSTR_WORDS] = '{default: 32'h0000_0013}
) (
  input logic                clk,
  input logic                rst_n,
  riscv_legacy_cpu_if.master bus
);

  localparam int unsigned IAW = $clog2(INSTR_WORDS);
  localparam int unsigned DAW = $clog2(DATA_WORDS);

  typedef enum logic [1:0] {ImmI = 2'd0, ImmS = 2'd1, ImmB = 2'd2, ImmJ = 2'd3} imm_src_e;
  typedef enum logic [2:0] {
    AluAdd = 3'd0, AluSub = 3'd1, AluAnd = 3'd2, AluOr = 3'd3, AluSlt = 3'd5
  } alu_op_e;
  typedef enum logic {SrcReg = 1'b0, SrcImm = 1'b1} alu_src_e;
  typedef enum logic [1:0] {ResAlu = 2'd0, ResMem = 2'd1, ResPc4 = 2'd2} res_src_e;
  typedef enum logic {PcPlus4 = 1'b0, PcTarget = 1'b1} pc_src_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [31:0] dmem_q [DATA_WORDS];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_we, mem_we, branch, jump, zero;
  imm_src_e    imm_src;
  alu_op_e     alu_ctrl;
  alu_src_e    alu_src;
  res_src_e    res_src;
  pc_src_e     pc_src;
  logic [31:0] imm_ext, rd1, rd2, src_b, alu_res, rd_data, result, pc_plus4, pc_target;

  assign instr  = IMEM_INIT[pc_q[IAW+1:2]];
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    imm_src  = ImmI;
    alu_src  = SrcReg;
    res_src  = ResAlu;
    alu_ctrl = AluAdd;
    case (opcode)
      7'b0000011: begin reg_we = 1'b1; alu_src = SrcImm; res_src = ResMem; end
      7'b0100011: begin mem_we = 1'b1; alu_src = SrcImm; imm_src = ImmS; end
      7'b0010011, 7'b0110011: begin
        reg_we  = 1'b1;
        alu_src = (opcode[5]) ? SrcReg : SrcImm;
        case (funct3)
          3'b000:  alu_ctrl = (opcode[5] && instr[30]) ? AluSub : AluAdd;
          3'b010:  alu_ctrl = AluSlt;
          3'b110:  alu_ctrl = AluOr;
          3'b111:  alu_ctrl = AluAnd;
          default: alu_ctrl = AluAdd;
        endcase
      end
      7'b1100011: begin branch = 1'b1; imm_src = ImmB; alu_ctrl = AluSub; end
      7'b1101111: begin reg_we = 1'b1; jump = 1'b1; imm_src = ImmJ; res_src = ResPc4; end
      default: ;
    endcase
  end

  always_comb begin
    unique case (imm_src)
      ImmI: imm_ext = {{20{instr[31]}}, instr[31:20]};
      ImmS: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB: imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmJ: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  end

  // x0 is forced to zero on read so it never depends on rf_q[0].
  assign rd1   = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rd2   = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign src_b = (alu_src == SrcImm) ? imm_ext : rd2;

  always_comb begin
    case (alu_ctrl)
      AluSub:  alu_res = rd1 - src_b;
      AluAnd:  alu_res = rd1 & src_b;
      AluOr:   alu_res = rd1 | src_b;
      AluSlt:  alu_res = {31'd0, $signed(rd1) < $signed(src_b)};
      default: alu_res = rd1 + src_b;
    endcase
  end

  assign zero      = (alu_res == 32'd0);
  assign pc_src    = ((branch && zero) || jump) ? PcTarget : PcPlus4;
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + imm_ext;
  assign rd_data   = dmem_q[alu_res[DAW+1:2]];

  always_comb begin
    case (res_src)
      ResMem:  result = rd_data;
      ResPc4:  result = pc_plus4;
      default: result = alu_res;
    endcase
  end

  always_comb begin
    pc_d = (pc_src == PcTarget) ? pc_target : pc_plus4;
    rf_d = rf_q;
    if (reg_we && (rd != 5'd0)) rf_d[rd] = result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
    end
  end

  // Data RAM has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) dmem_q[alu_res[DAW+1:2]] <= rd2;
  end

  assign bus.reg_we      = reg_we;
  assign bus.mem_we      = mem_we;
  assign bus.imm_src     = imm_src;
  assign bus.alu_ctrl    = alu_ctrl;
  assign bus.alu_src     = alu_src;
  assign bus.res_src     = res_src;
  assign bus.pc_src      = pc_src;
  assign bus.instr       = instr;
  assign bus.alu_out     = alu_res;
  assign bus.mem_rd_data = rd_data;
  assign bus.mem_wd_data = rd2;
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_riscv_legacy_cpu.sv
// Bench for riscv_legacy_cpu: directed program run plus randomly timed reset rounds, all
// checked against an instruction-level interpreter of the same program.
module tb_riscv_legacy_cpu;

  localparam logic [31:0] PROG [64] = '{
    0: 32'h00500113,  1: 32'h00C00193,  2: 32'hFF718393,  3: 32'h0023E233,
    4: 32'h0041F2B3,  5: 32'h004282B3,  6: 32'h02728863,  7: 32'h0041A233,
    8: 32'h00020463,  9: 32'h00000293, 10: 32'h0023A233, 11: 32'h005203B3,
   12: 32'h402383B3, 13: 32'h0471AA23, 14: 32'h06002103, 15: 32'h005104B3,
   16: 32'h008001EF, 17: 32'h00100113, 18: 32'h00910133, 19: 32'h0221A023,
   20: 32'h00210063, default: 32'h00000013
  };

  logic clk;
  logic rst_n;
  riscv_legacy_cpu_if bus ();

  riscv_legacy_cpu #(
    .INSTR_WORDS (64),
    .DATA_WORDS  (64),
    .IMEM_INIT   (PROG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural reference state
  logic [31:0] m_pc;
  logic [31:0] m_rf [32];
  logic [31:0] m_dmem [64];
  bit          m_dval [64];

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input bit sub);
    case (f3)
      3'd0:    return sub ? a - b : a + b;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a | b;
      3'd7:    return a & b;
      default: return a + b;
    endcase
  endfunction

  // Executes one instruction of the model, returning what the decode bus should show.
  task automatic model_step(output logic [31:0] e_alu, output bit e_has_alu,
                            output bit e_reg_we, output bit e_mem_we,
                            output bit e_pc_src, output logic [1:0] e_res_src,
                            output logic [31:0] e_wd);
    logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, nxt, wval;
    logic [7:0]  pidx;
    logic [4:0]  rd;
    bit          wr;
    pidx  = m_pc[7:0];
    ins   = PROG[pidx[7:2]];
    rd    = ins[11:7];
    a     = m_rf[ins[19:15]];
    b     = m_rf[ins[24:20]];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 32'd4;
    wr = 0; wval = 32'd0; e_alu = 32'd0; e_has_alu = 0;
    e_mem_we = 0; e_res_src = 2'd0; e_wd = b;
    case (ins[6:0])
      7'h03: begin
        e_alu = a + imm_i; e_has_alu = 1; wr = 1; e_res_src = 2'd1;
        wval = m_dmem[e_alu[7:2]];
      end
      7'h23: begin
        e_alu = a + imm_s; e_has_alu = 1; e_mem_we = 1;
        m_dmem[e_alu[7:2]] = b; m_dval[e_alu[7:2]] = 1;
      end
      7'h13: begin e_alu = alu_fn(a, imm_i, ins[14:12], 0); e_has_alu = 1; wr = 1; wval = e_alu; end
      7'h33: begin
        e_alu = alu_fn(a, b, ins[14:12], ins[30]); e_has_alu = 1; wr = 1; wval = e_alu;
      end
      7'h63: if (a == b) nxt = m_pc + imm_b;
      7'h6F: begin wr = 1; wval = m_pc + 32'd4; nxt = m_pc + imm_j; e_res_src = 2'd2; end
      default: ;
    endcase
    e_reg_we = wr;
    e_pc_src = (nxt != m_pc + 32'd4);
    if (wr && rd != 5'd0) m_rf[rd] = wval;
    m_pc = nxt;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("%s_x%0d", tag, i), dut.rf_q[i], m_rf[i]);
  endtask

  task automatic run_cycles(input int n);
    logic [31:0] e_alu, e_wd;
    logic [1:0]  e_res;
    bit          e_has, e_rwe, e_mwe, e_psrc;
    for (int c = 0; c < n; c++) begin
      check_eq("instr", bus.instr, PROG[m_pc[7:2]]);
      model_step(e_alu, e_has, e_rwe, e_mwe, e_psrc, e_res, e_wd);
      if (e_has) check_eq("alu_out", bus.alu_out, e_alu);
      check_eq("reg_we", {31'd0, bus.reg_we}, {31'd0, e_rwe});
      check_eq("mem_we", {31'd0, bus.mem_we}, {31'd0, e_mwe});
      check_eq("pc_src", {31'd0, bus.pc_src}, {31'd0, e_psrc});
      if (e_rwe) check_eq("res_src", {30'd0, bus.res_src}, {30'd0, e_res});
      if (e_mwe) check_eq("mem_wd_data", bus.mem_wd_data, e_wd);
      @(posedge clk);
      #1;
      check_eq("pc", bus.pc, m_pc);
      check_regs("step");
    end
  endtask

  task automatic check_dmem();
    for (int i = 0; i < 64; i++)
      if (m_dval[i]) check_eq($sformatf("dmem%0d", i), dut.dmem_q[i], m_dmem[i]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin m_dmem[i] = 32'd0; m_dval[i] = 0; end
    rst_n = 1'b0;
    model_reset();
    #2;
    check_eq("rst_pc", bus.pc, 32'd0);
    check_eq("rst_alu_out", bus.alu_out, 32'd5);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_pc", bus.pc, 32'd0);
    check_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed walk through the program with spot values from the program's intent
    run_cycles(1);
    check_eq("first_pc", bus.pc, 32'd4);
    check_eq("first_x2", dut.rf_q[2], 32'd5);
    run_cycles(5);
    check_eq("x3", dut.rf_q[3], 32'd12);
    check_eq("x7", dut.rf_q[7], 32'd3);
    check_eq("x4", dut.rf_q[4], 32'd7);
    check_eq("x5", dut.rf_q[5], 32'd11);
    run_cycles(1);
    check_eq("beq_not_taken", bus.pc, 32'h1C);
    run_cycles(1);
    check_eq("slt_x4_0", dut.rf_q[4], 32'd0);
    run_cycles(1);
    check_eq("beq_taken", bus.pc, 32'd40);
    run_cycles(1);
    check_eq("slt_x4_1", dut.rf_q[4], 32'd1);
    run_cycles(5);
    check_eq("dmem24", dut.dmem_q[24], 32'd7);
    check_eq("lw_x2", dut.rf_q[2], 32'd7);
    check_eq("x9", dut.rf_q[9], 32'd18);
    check_eq("pre_jal_pc", bus.pc, 32'd64);
    run_cycles(1);
    check_eq("jal_pc", bus.pc, 32'd72);
    check_eq("jal_x3", dut.rf_q[3], 32'd68);
    run_cycles(2);
    check_eq("x2_25", dut.rf_q[2], 32'd25);
    check_eq("dmem25", dut.dmem_q[25], 32'd25);
    for (int i = 0; i < 4; i++) begin
      run_cycles(1);
      check_eq("self_loop_pc", bus.pc, 32'd80);
    end
    check_dmem();

    // Asynchronous reset in the middle of a cycle
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_pc", bus.pc, 32'd0);
    check_regs("async_rst");

    // Randomly sized runs, each cut short by a randomly timed reset
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      rst_n = 1'b1;
      run_cycles($urandom_range(1, 30));
      check_dmem();
      #($urandom_range(0, 7));
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("rand_rst_pc", bus.pc, 32'd0);
      check_regs("rand_rst");
      check_eq("rand_rst_alu_out", bus.alu_out, 32'd5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
